// File: rtl/counter_sequencer.sv
// Run/stop and direction sequencer for the 4-bit display counter: debounced buttons,
// tick prescaler and the count register feeding the 7-segment encoder.
module counter_sequencer #(
    parameter int DIV      = 12587500,
    parameter int DEBOUNCE = 500000,
    parameter int CNT_MAX  = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_RUN,
    input  logic       BTN_DIR,
    input  logic       BTN_CLR,
    input  logic       MODE_BOUNCE,
    output logic [3:0] COUNT,
    output logic       ADD_SUB,
    output logic       TICK,
    output logic       RUNNING
);

    localparam int PRE_W = $clog2(DIV);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [3:0]       CMAX     = 4'(CNT_MAX);

    localparam logic [0:0] ST_STOP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Button bit order: [0]=run, [1]=dir, [2]=clr
    logic [2:0]      btn_raw;
    logic [2:0]      sync_p0;
    logic [2:0]      sync_p1;
    logic [2:0]      filt;
    logic [2:0]      filt_d;
    logic [2:0]      prs;
    logic [DB_W-1:0] db_cnt [3];

    logic             prs_run;
    logic             prs_dir;
    logic             prs_clr;

    logic [0:0]       state;
    logic [0:0]       state_n;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_n;
    logic [3:0]       count_n;
    logic             add_sub_n;
    logic             tick_n;
    logic             step_ev;

    function automatic logic [3:0] step_count(input logic [3:0] c, input logic up,
                                              input logic bounce);
        logic [3:0] r;
        if (up) begin
            if (c < CMAX)    r = c + 4'd1;
            else if (bounce) r = CMAX - 4'd1;
            else             r = 4'd0;
        end else begin
            if (c != 4'd0)   r = c - 4'd1;
            else if (bounce) r = 4'd1;
            else             r = CMAX;
        end
        return r;
    endfunction

    function automatic logic step_dir(input logic [3:0] c, input logic up,
                                      input logic bounce);
        logic r;
        r = up;
        if (bounce && up && (c == CMAX))    r = 1'b0;
        if (bounce && !up && (c == 4'd0))   r = 1'b1;
        return r;
    endfunction

    assign btn_raw = {BTN_CLR, BTN_DIR, BTN_RUN};

    // Stage p0/p1: two-flop synchroniser on the raw buttons
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce filter and registered rising-edge press pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            filt   <= '0;
            filt_d <= '0;
            prs    <= '0;
            for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
        end else begin
            filt_d <= filt;
            prs    <= filt & ~filt_d;
            for (int b = 0; b < 3; b++) begin
                if (sync_p1[b] == filt[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    filt[b]   <= sync_p1[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + DB_W'(1);
                end
            end
        end
    end

    assign prs_run = prs[0];
    assign prs_dir = prs[1];
    assign prs_clr = prs[2];

    // Clear wins over everything; a direction press lets a coincident step use the old direction
    always_comb begin
        step_ev   = (state == ST_RUN) && (pre == PRE_LAST);
        state_n   = state;
        pre_n     = '0;
        count_n   = COUNT;
        add_sub_n = ADD_SUB;
        tick_n    = 1'b0;
        if (state == ST_RUN) pre_n = step_ev ? '0 : pre + PRE_W'(1);
        if (prs_clr) begin
            count_n = '0;
            pre_n   = '0;
        end else begin
            if (step_ev) begin
                count_n   = step_count(COUNT, ADD_SUB, MODE_BOUNCE);
                add_sub_n = step_dir(COUNT, ADD_SUB, MODE_BOUNCE);
                tick_n    = 1'b1;
            end
            if (prs_dir) add_sub_n = ~ADD_SUB;
            if (prs_run) begin
                state_n = (state == ST_RUN) ? ST_STOP : ST_RUN;
                pre_n   = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_STOP;
            pre     <= '0;
            COUNT   <= '0;
            ADD_SUB <= 1'b1;
            TICK    <= 1'b0;
            RUNNING <= 1'b0;
        end else begin
            state   <= state_n;
            pre     <= pre_n;
            COUNT   <= count_n;
            ADD_SUB <= add_sub_n;
            TICK    <= tick_n;
            RUNNING <= (state_n == ST_RUN);
        end
    end

endmodule
